player_motion: RTL and testbench
================================

Name: player_motion

Overview:
Parametrised successor to the single-player position block. It steps the player angle once per frame strobe, using a difficulty-selected speed. Movement ramps from half speed to full speed while a button is held. A small FSM sequences the registered sincos lookup and scales the result to screen coordinates, signalling completion with a valid pulse. Collision revert is supported, including a revert that arrives while a lookup is in flight. The block sits between button/difficulty inputs and the renderer/collision logic.

Parameters:
ANGLE_W, 10, angle width in bits; one full turn = 2^ANGLE_W; must be >= 10
COORD_W, 10, signed coordinate width
TRIG_W, 12, signed sin/cos width from the sincos sub-module
SHIFT_A, 6, first radius shift
SHIFT_B, 7, second radius shift
TRIG_LAT, 1, sincos latency in cycles (>= 1)
RAMP_FRAMES, 4, number of half-speed frames before full speed applies

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
update  in  1  frame strobe; one step request
revert  in  1  collision revert request
difficulty  in  2  speed select
cw_btn  in  1  clockwise button
ccw_btn  in  1  counter-clockwise button
angle  out  ANGLE_W  current angle
x, y  out  COORD_W signed  current position
x_old, y_old  out  COORD_W signed  position before the last accepted update
busy  out  1  high in LOOKUP, SCALE and INIT
valid  out  1  one-cycle pulse when x/y have been written

Behaviour:
- Reset (rst_n low at an edge):
  - angle, old_angle, x, y, x_old, y_old = 0; ramp_cnt = 0; revert_pend = 0; valid = 0.
  - State = INIT.
  - After rst_n rises, INIT waits TRIG_LAT cycles, then SCALE runs and valid pulses.
  - With the standard sincos, this yields x = 46, y = 0.
  - Reset mid-operation aborts any lookup and drops pending reverts.
- Speed base: 8, 12, 16, 20 for difficulty 0..3, scaled by << (ANGLE_W-10). Difficulty is sampled at the update edge.
- Step size: base>>1 while ramp_cnt < RAMP_FRAMES, otherwise base.
- Direction: cw_btn has priority over ccw_btn. cw adds the step, ccw subtracts it. Angle wraps modulo 2^ANGLE_W.
- Ramp counter:
  - increments, saturating at RAMP_FRAMES, on each accepted update with the same direction as the previous accepted update;
  - set to 1 on a direction change or the first press;
  - cleared on an update with no button, and on an applied revert.
  - The step uses the count value before the increment.
- FSM states: IDLE, LOOKUP, SCALE, INIT.
  - IDLE with update=1, revert=0, at edge k:
    - x_old <= x, y_old <= y, old_angle <= angle;
    - angle <= stepped value;
    - state <= LOOKUP.
  - LOOKUP lasts TRIG_LAT cycles, then state <= SCALE.
  - SCALE: x <= (cos>>>SHIFT_A) + (cos>>>SHIFT_B), y likewise from sin. Shifts are arithmetic; results are sign-extended and truncated to COORD_W. valid is high in the following cycle; state <= IDLE.
  - With TRIG_LAT=1, x/y/valid appear after edge k+2.
- Update with no button pressed still runs LOOKUP/SCALE (angle unchanged), and old values are still captured.
- update while busy: dropped. No queueing, no state change.
- revert in IDLE: angle <= old_angle, x <= x_old, y <= y_old, all in one cycle; ramp_cnt cleared; no valid pulse.
- revert and update together in IDLE: revert wins; the update is dropped.
- revert while busy: sets revert_pend. At SCALE, x/y load x_old/y_old instead of the new values, angle <= old_angle, and revert_pend clears. valid still pulses.
- Repeated reverts are idempotent.
- sincos contract:
  - angle 0 gives cos = +2047, sin = 0;
  - angle 2^(ANGLE_W-2) gives sin = +2047, cos = 0;
  - output is registered with latency TRIG_LAT.

Decomposition:
- Shared package (player_pkg) holds:
  - the speed table constants (8/12/16/20);
  - the FSM state encoding (IDLE, LOOKUP, SCALE, INIT);
  - the difficulty enum.
- One sub-module: the existing sincos, parametrised on ANGLE_W/TRIG_W.
- The ramp counter and radius scaling stay inline.

Test Plan:
1. Release rst_n and hold all inputs low -> busy for 2 cycles, one valid pulse, x=46, y=0, angle=0.
2. difficulty=0, cw held across 5 updates spaced 4 cycles apart -> angle 4, 8, 12, 16, 24 (ramp saturates after 4 frames).
3. From angle 0: difficulty=3, ccw for one update -> angle 1014 (wrap, half step 10). Then cw for the next update -> angle 1024 mod 1024 = 0, ramp reset to 1.
4. Update at angle 0 with cw, then revert 5 cycles later -> angle=0, x=46, y=0, x_old/y_old unchanged, no valid pulse.
5. Update, then a second update and a revert one cycle later (while busy) -> second update ignored; valid pulses after edge k+2 with x/y = pre-update values; angle restored.
6. cw_btn and ccw_btn both high, difficulty=1, ramp saturated -> angle increases by 12.

Source files
------------

// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared types and speed table for player_motion
package player_pkg;

  // Base angular speed per difficulty, expressed for a 10-bit turn
  localparam logic [4:0] SPEED_EASY   = 5'd8;
  localparam logic [4:0] SPEED_NORMAL = 5'd12;
  localparam logic [4:0] SPEED_HARD   = 5'd16;
  localparam logic [4:0] SPEED_EXPERT = 5'd20;

  typedef enum logic [1:0] {
    DIFF_EASY   = 2'd0,
    DIFF_NORMAL = 2'd1,
    DIFF_HARD   = 2'd2,
    DIFF_EXPERT = 2'd3
  } difficulty_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_SCALE  = 2'd2,
    ST_INIT   = 2'd3
  } state_e;

  // Direction of the last accepted update; NONE makes the next press a first press
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } dir_e;

  function automatic logic [4:0] speed_base(input difficulty_e d);
    case (d)
      DIFF_EASY:   return SPEED_EASY;
      DIFF_NORMAL: return SPEED_NORMAL;
      DIFF_HARD:   return SPEED_HARD;
      default:     return SPEED_EXPERT;
    endcase
  endfunction

endpackage

// File: rtl/player_motion_sincos.sv
// rtl/player_motion_sincos.sv - registered parabolic sin/cos lookup
// Each half turn is approximated by amp*h*(2Q-h)/Q^2 (Q = quarter turn),
// negated in the second half; cos is sin shifted by a quarter turn.
module player_motion_sincos #(
  parameter int ANGLE_W  = 10,
  parameter int TRIG_W   = 12,
  parameter int TRIG_LAT = 1
) (
  input  logic                      i_clk,
  input  logic [ANGLE_W-1:0]        i_angle,
  output logic signed [TRIG_W-1:0]  o_sin,
  output logic signed [TRIG_W-1:0]  o_cos
);

  localparam int QW = ANGLE_W - 2;
  localparam int PW = 2 * QW + TRIG_W;
  localparam logic [TRIG_W-1:0]  AMP     = {1'b0, {(TRIG_W-1){1'b1}}};
  localparam logic [ANGLE_W-1:0] QUARTER = ANGLE_W'(1) << QW;
  localparam logic [ANGLE_W-1:0] HALF    = ANGLE_W'(1) << (ANGLE_W - 1);

  function automatic logic signed [TRIG_W-1:0] half_wave(input logic [ANGLE_W-1:0] a);
    logic [ANGLE_W-1:0] h;
    logic [ANGLE_W-1:0] span;
    logic [PW-1:0]      prod;
    logic [TRIG_W-1:0]  mag;
    h    = {1'b0, a[ANGLE_W-2:0]};
    span = HALF - h;
    prod = PW'(h) * PW'(span) * PW'(AMP);
    mag  = TRIG_W'(prod >> (2 * QW));
    return a[ANGLE_W-1] ? -$signed(mag) : $signed(mag);
  endfunction

  logic signed [TRIG_W-1:0] r_sin [0:TRIG_LAT-1];
  logic signed [TRIG_W-1:0] r_cos [0:TRIG_LAT-1];

  // Evaluate in the first stage, then delay through the remaining stages
  always_ff @(posedge i_clk) begin
    r_sin[0] <= half_wave(i_angle);
    r_cos[0] <= half_wave(i_angle + QUARTER);
    for (int i = 1; i < TRIG_LAT; i++) begin
      r_sin[i] <= r_sin[i-1];
      r_cos[i] <= r_cos[i-1];
    end
  end

  assign o_sin = r_sin[TRIG_LAT-1];
  assign o_cos = r_cos[TRIG_LAT-1];

endmodule

// File: rtl/player_motion.sv
// rtl/player_motion.sv - per-frame player angle stepping with sincos position
module player_motion
  import player_pkg::*;
#(
  parameter int ANGLE_W     = 10,
  parameter int COORD_W     = 10,
  parameter int TRIG_W      = 12,
  parameter int SHIFT_A     = 6,
  parameter int SHIFT_B     = 7,
  parameter int TRIG_LAT    = 1,
  parameter int RAMP_FRAMES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      update,
  input  logic                      revert,
  input  logic [1:0]                difficulty,
  input  logic                      cw_btn,
  input  logic                      ccw_btn,
  output logic [ANGLE_W-1:0]        angle,
  output logic signed [COORD_W-1:0] x,
  output logic signed [COORD_W-1:0] y,
  output logic signed [COORD_W-1:0] x_old,
  output logic signed [COORD_W-1:0] y_old,
  output logic                      busy,
  output logic                      valid
);

  localparam int RAMP_W = (RAMP_FRAMES < 1) ? 1 : $clog2(RAMP_FRAMES + 1);
  localparam int LAT_W  = (TRIG_LAT > 1) ? $clog2(TRIG_LAT) : 1;

  state_e                    r_state;
  state_e                    w_state_next;
  logic [ANGLE_W-1:0]        r_angle;
  logic [ANGLE_W-1:0]        r_old_angle;
  logic signed [COORD_W-1:0] r_x;
  logic signed [COORD_W-1:0] r_y;
  logic signed [COORD_W-1:0] r_x_old;
  logic signed [COORD_W-1:0] r_y_old;
  logic [RAMP_W-1:0]         r_ramp;
  dir_e                      r_last_dir;
  logic                      r_revert_pend;
  logic                      r_valid;
  logic [LAT_W-1:0]          r_lat_cnt;

  logic signed [TRIG_W-1:0]  w_sin;
  logic signed [TRIG_W-1:0]  w_cos;
  logic [ANGLE_W-1:0]        w_base;
  logic [ANGLE_W-1:0]        w_step;
  dir_e                      w_dir;
  logic [ANGLE_W-1:0]        w_angle_step;
  logic [RAMP_W-1:0]         w_ramp_next;
  logic signed [COORD_W-1:0] w_x_new;
  logic signed [COORD_W-1:0] w_y_new;
  logic                      w_lat_done;
  logic                      w_take_revert;

  player_motion_sincos #(
    .ANGLE_W  (ANGLE_W),
    .TRIG_W   (TRIG_W),
    .TRIG_LAT (TRIG_LAT)
  ) u_sincos (
    .i_clk   (clk),
    .i_angle (r_angle),
    .o_sin   (w_sin),
    .o_cos   (w_cos)
  );

  // Step size, direction, ramp bookkeeping and radius scaling
  always_comb begin
    w_base = ANGLE_W'(speed_base(difficulty_e'(difficulty))) << (ANGLE_W - 10);
    w_step = (r_ramp < RAMP_W'(RAMP_FRAMES)) ? (w_base >> 1) : w_base;

    // Clockwise wins when both buttons are held
    if (cw_btn)       w_dir = DIR_CW;
    else if (ccw_btn) w_dir = DIR_CCW;
    else              w_dir = DIR_NONE;

    case (w_dir)
      DIR_CW:  w_angle_step = r_angle + w_step;
      DIR_CCW: w_angle_step = r_angle - w_step;
      default: w_angle_step = r_angle;
    endcase

    if (w_dir == DIR_NONE)
      w_ramp_next = '0;
    else if (w_dir != r_last_dir)
      w_ramp_next = RAMP_W'(1);
    else if (r_ramp < RAMP_W'(RAMP_FRAMES))
      w_ramp_next = r_ramp + RAMP_W'(1);
    else
      w_ramp_next = r_ramp;

    // Radius is cos/2^A + cos/2^B, computed wide so sign extension is exact
    w_x_new = COORD_W'((32'(w_cos) >>> SHIFT_A) + (32'(w_cos) >>> SHIFT_B));
    w_y_new = COORD_W'((32'(w_sin) >>> SHIFT_A) + (32'(w_sin) >>> SHIFT_B));

    w_lat_done    = (r_lat_cnt == LAT_W'(TRIG_LAT - 1));
    w_take_revert = r_revert_pend | revert;
  end

  // Next-state selection; updates are only accepted from IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (update && !revert) w_state_next = ST_LOOKUP;
      ST_LOOKUP: if (w_lat_done) w_state_next = ST_SCALE;
      ST_INIT:   if (w_lat_done) w_state_next = ST_SCALE;
      ST_SCALE:  w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // State register; reset restarts with an initial lookup of angle 0
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_next;
  end

  // Angle, position, ramp and revert bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_angle       <= '0;
      r_old_angle   <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_x_old       <= '0;
      r_y_old       <= '0;
      r_ramp        <= '0;
      r_last_dir    <= DIR_NONE;
      r_revert_pend <= 1'b0;
      r_valid       <= 1'b0;
      r_lat_cnt     <= '0;
    end else begin
      r_valid <= (r_state == ST_SCALE);
      case (r_state)
        ST_IDLE: begin
          if (revert) begin
            r_angle <= r_old_angle;
            r_x     <= r_x_old;
            r_y     <= r_y_old;
            r_ramp  <= '0;
          end else if (update) begin
            r_x_old     <= r_x;
            r_y_old     <= r_y;
            r_old_angle <= r_angle;
            r_angle     <= w_angle_step;
            r_ramp      <= w_ramp_next;
            r_last_dir  <= w_dir;
            r_lat_cnt   <= '0;
          end
        end
        ST_LOOKUP, ST_INIT: begin
          r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          if (revert) r_revert_pend <= 1'b1;
        end
        ST_SCALE: begin
          if (w_take_revert) begin
            r_x           <= r_x_old;
            r_y           <= r_y_old;
            r_angle       <= r_old_angle;
            r_ramp        <= '0;
            r_revert_pend <= 1'b0;
          end else begin
            r_x <= w_x_new;
            r_y <= w_y_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign angle = r_angle;
  assign x     = r_x;
  assign y     = r_y;
  assign x_old = r_x_old;
  assign y_old = r_y_old;
  assign busy  = (r_state != ST_IDLE);
  assign valid = r_valid;

endmodule

// File: tb/tb_player_motion.sv
// tb/tb_player_motion.sv - randomized model-checked bench for player_motion
module tb_player_motion;

  localparam int ANGLE_W     = 10;
  localparam int COORD_W     = 10;
  localparam int TRIG_W      = 12;
  localparam int SHIFT_A     = 6;
  localparam int SHIFT_B     = 7;
  localparam int TRIG_LAT    = 1;
  localparam int RAMP_FRAMES = 4;
  localparam int TURN        = 1 << ANGLE_W;
  localparam int AMP         = (1 << (TRIG_W - 1)) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic update = 1'b0;
  logic revert = 1'b0;
  logic [1:0] difficulty = 2'd0;
  logic cw_btn = 1'b0;
  logic ccw_btn = 1'b0;
  logic [ANGLE_W-1:0] angle;
  logic signed [COORD_W-1:0] x, y, x_old, y_old;
  logic busy, valid;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference state
  int m_angle, m_old, m_x, m_y, m_xo, m_yo, m_ramp, m_last, m_pend, m_left, m_valid;

  player_motion #(
    .ANGLE_W(ANGLE_W), .COORD_W(COORD_W), .TRIG_W(TRIG_W), .SHIFT_A(SHIFT_A),
    .SHIFT_B(SHIFT_B), .TRIG_LAT(TRIG_LAT), .RAMP_FRAMES(RAMP_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .update(update), .revert(revert),
    .difficulty(difficulty), .cw_btn(cw_btn), .ccw_btn(ccw_btn),
    .angle(angle), .x(x), .y(y), .x_old(x_old), .y_old(y_old),
    .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Half-turn parabola sine: amp*h*(2Q-h)/Q^2, negative in the second half turn
  function automatic int m_sin(input int a);
    int half;
    int h;
    longint mag;
    half = TURN / 2;
    h = a % half;
    mag = (longint'(AMP) * h * (half - h)) / (longint'(TURN / 4) * (TURN / 4));
    return (a >= half) ? -int'(mag) : int'(mag);
  endfunction

  function automatic int m_cos(input int a);
    return m_sin((a + TURN / 4) % TURN);
  endfunction

  function automatic int to_coord(input int t);
    int v;
    v = (t >>> SHIFT_A) + (t >>> SHIFT_B);
    v = v & ((1 << COORD_W) - 1);
    if (v >= (1 << (COORD_W - 1))) v -= (1 << COORD_W);
    return v;
  endfunction

  // Reference model, advanced on each rising edge from the sampled inputs
  always @(posedge clk) begin
    int base, step, dir;
    if (!rst_n) begin
      m_angle = 0; m_old = 0; m_x = 0; m_y = 0; m_xo = 0; m_yo = 0;
      m_ramp = 0; m_last = 0; m_pend = 0; m_valid = 0;
      m_left = TRIG_LAT + 1;
    end else begin
      m_valid = 0;
      if (m_left == 0) begin
        if (revert) begin
          m_angle = m_old; m_x = m_xo; m_y = m_yo; m_ramp = 0;
        end else if (update) begin
          base = (8 + 4 * int'(difficulty)) << (ANGLE_W - 10);
          step = (m_ramp < RAMP_FRAMES) ? base / 2 : base;
          dir = cw_btn ? 1 : (ccw_btn ? 2 : 0);
          m_xo = m_x; m_yo = m_y; m_old = m_angle;
          if (dir == 1) m_angle = (m_angle + step) % TURN;
          if (dir == 2) m_angle = (m_angle - step + TURN) % TURN;
          if (dir == 0) m_ramp = 0;
          else if (dir == m_last) m_ramp = (m_ramp + 1 > RAMP_FRAMES) ? RAMP_FRAMES : m_ramp + 1;
          else m_ramp = 1;
          m_last = dir;
          m_left = TRIG_LAT + 1;
        end
      end else begin
        if (revert) m_pend = 1;
        m_left--;
        if (m_left == 0) begin
          if (m_pend != 0) begin
            m_x = m_xo; m_y = m_yo; m_angle = m_old; m_ramp = 0; m_pend = 0;
          end else begin
            m_x = to_coord(m_cos(m_angle));
            m_y = to_coord(m_sin(m_angle));
          end
          m_valid = 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("angle", int'(angle), m_angle);
      check("x", int'(x), m_x);
      check("y", int'(y), m_y);
      check("x_old", int'(x_old), m_xo);
      check("y_old", int'(y_old), m_yo);
      check("busy", int'(busy), (m_left > 0) ? 1 : 0);
      check("valid", int'(valid), m_valid);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_update(input bit cw, input bit ccw, input int diff);
    @(negedge clk);
    cw_btn = cw; ccw_btn = ccw; difficulty = 2'(diff); update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    rst_n = 1'b0; update = 1'b0; revert = 1'b0; cw_btn = 1'b0; ccw_btn = 1'b0;
    difficulty = 2'd0;
    tick(2);
    chk_en = 1'b1;
    rst_n = 1'b1;
    n = 0;
    while (!valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("init_valid_timeout", 0, 1);
  endtask

  initial begin
    // 1: reset and initial lookup
    do_reset();
    check("t1_x", int'(x), 46);
    check("t1_y", int'(y), 0);
    check("t1_angle", int'(angle), 0);
    tick(2);

    // 2: ramp from half to full speed at difficulty 0
    begin
      int exp_a [5] = '{4, 8, 12, 16, 24};
      for (int i = 0; i < 5; i++) begin
        do_update(1'b1, 1'b0, 0);
        tick(2);
        check($sformatf("t2_angle%0d", i), int'(angle), exp_a[i]);
      end
    end

    // 3: wrap below zero, then direction change
    do_reset();
    do_update(1'b0, 1'b1, 3);
    tick(3);
    check("t3_ccw", int'(angle), 1014);
    do_update(1'b1, 1'b0, 3);
    tick(3);
    check("t3_cw", int'(angle), 0);

    // 4: idle revert restores the pre-update position without a valid pulse
    do_update(1'b1, 1'b0, 0);
    tick(4);
    revert = 1'b1;
    @(negedge clk);
    revert = 1'b0;
    tick(1);
    check("t4_angle", int'(angle), 0);
    check("t4_x", int'(x), 46);
    check("t4_y", int'(y), 0);
    check("t4_x_old", int'(x_old), 46);
    check("t4_y_old", int'(y_old), 0);

    // 5: revert while busy, with a dropped second update
    do_update(1'b1, 1'b0, 2);
    update = 1'b1; revert = 1'b1;
    @(negedge clk);
    update = 1'b0; revert = 1'b0;
    tick(3);
    check("t5_angle", int'(angle), 0);
    check("t5_x", int'(x), 46);
    check("t5_y", int'(y), 0);

    // 6: both buttons held resolves to clockwise
    do_reset();
    begin
      int exp_b [5] = '{6, 12, 18, 24, 36};
      for (int i = 0; i < 5; i++) begin
        do_update(1'b1, 1'b1, 1);
        tick(2);
        check($sformatf("t6_angle%0d", i), int'(angle), exp_b[i]);
      end
    end

    // Randomized traffic, including occasional mid-operation resets
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      rst_n      = ($urandom_range(0, 299) != 0);
      update     = ($urandom_range(0, 2) == 0);
      revert     = ($urandom_range(0, 9) == 0);
      cw_btn     = ($urandom_range(0, 2) == 0);
      ccw_btn    = ($urandom_range(0, 2) == 0);
      difficulty = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    rst_n = 1'b1; update = 1'b0; revert = 1'b0;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
